// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters.
// Each accepted request gets a single-cycle response pulse carrying result, carry and illegal-op flag.
module alu_arbiter #(
  parameter int unsigned BUS_SIZE    = 8,
  parameter int unsigned OP_SIZE     = 6,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_req0_valid,
  input  logic [BUS_SIZE-1:0] i_req0_a,
  input  logic [BUS_SIZE-1:0] i_req0_b,
  input  logic [OP_SIZE-1:0]  i_req0_op,
  output logic                o_req0_ready,
  input  logic                i_req1_valid,
  input  logic [BUS_SIZE-1:0] i_req1_a,
  input  logic [BUS_SIZE-1:0] i_req1_b,
  input  logic [OP_SIZE-1:0]  i_req1_op,
  output logic                o_req1_ready,
  output logic                o_rsp0_valid,
  output logic [BUS_SIZE-1:0] o_rsp0_result,
  output logic                o_rsp0_carry,
  output logic                o_rsp0_err,
  output logic                o_rsp1_valid,
  output logic [BUS_SIZE-1:0] o_rsp1_result,
  output logic                o_rsp1_carry,
  output logic                o_rsp1_err,
  output logic [BUS_SIZE-1:0] o_alu_a,
  output logic [BUS_SIZE-1:0] o_alu_b,
  output logic [OP_SIZE-1:0]  o_alu_op,
  input  logic [BUS_SIZE-1:0] i_alu_result,
  input  logic                i_alu_carry,
  output logic                o_busy
);

  localparam int unsigned CNT_W = 4;

  localparam logic [OP_SIZE-1:0] OP_ADD = OP_SIZE'(6'b100000);
  localparam logic [OP_SIZE-1:0] OP_SUB = OP_SIZE'(6'b100010);
  localparam logic [OP_SIZE-1:0] OP_AND = OP_SIZE'(6'b100100);
  localparam logic [OP_SIZE-1:0] OP_OR  = OP_SIZE'(6'b100101);
  localparam logic [OP_SIZE-1:0] OP_XOR = OP_SIZE'(6'b100110);
  localparam logic [OP_SIZE-1:0] OP_NOR = OP_SIZE'(6'b100111);
  localparam logic [OP_SIZE-1:0] OP_SRL = OP_SIZE'(6'b000010);
  localparam logic [OP_SIZE-1:0] OP_SRA = OP_SIZE'(6'b000011);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     ptr_q, ptr_d;    // 0 favours req0 on contention
  logic                     win_q, win_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BUS_SIZE-1:0]      alu_a_q, alu_a_d;
  logic [BUS_SIZE-1:0]      alu_b_q, alu_b_d;
  logic [OP_SIZE-1:0]       alu_op_q, alu_op_d;
  logic [1:0]               rsp_valid_q, rsp_valid_d;
  logic [1:0][BUS_SIZE-1:0] rsp_result_q, rsp_result_d;
  logic [1:0]               rsp_carry_q, rsp_carry_d;
  logic [1:0]               rsp_err_q, rsp_err_d;

  logic                grant_c;
  logic                accept_c;
  logic                op_legal_c;
  logic [BUS_SIZE-1:0] sel_a_c;
  logic [BUS_SIZE-1:0] sel_b_c;
  logic [OP_SIZE-1:0]  sel_op_c;

  // Winner selection: sole valid requester, otherwise the pointer decides.
  always_comb begin
    grant_c = i_req1_valid;
    if (i_req0_valid && i_req1_valid) begin
      grant_c = ptr_q;
    end
    accept_c = (state_q == ST_IDLE) && (i_req0_valid || i_req1_valid);
    sel_a_c  = grant_c ? i_req1_a  : i_req0_a;
    sel_b_c  = grant_c ? i_req1_b  : i_req0_b;
    sel_op_c = grant_c ? i_req1_op : i_req0_op;
  end

  always_comb begin
    op_legal_c = 1'b0;
    case (sel_op_c)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA: op_legal_c = 1'b1;
      default: op_legal_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = '0;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          win_d = grant_c;
          ptr_d = ~grant_c;
          if (op_legal_c) begin
            alu_a_d  = sel_a_c;
            alu_b_d  = sel_b_c;
            alu_op_d = sel_op_c;
            cnt_d    = CNT_W'(ALU_LATENCY);
            state_d  = ST_EXEC;
          end else begin
            // Illegal opcode never reaches the ALU; answer straight away.
            rsp_result_d[grant_c] = '0;
            rsp_carry_d[grant_c]  = 1'b0;
            rsp_err_d[grant_c]    = 1'b1;
            rsp_valid_d[grant_c]  = 1'b1;
            state_d               = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_result_d[win_q] = i_alu_result;
          rsp_carry_d[win_q]  = i_alu_carry;
          rsp_err_d[win_q]    = 1'b0;
          rsp_valid_d[win_q]  = 1'b1;
          state_d             = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      win_q        <= 1'b0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= '0;
      rsp_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign o_req0_ready  = i_reset_n && (state_q == ST_IDLE) && !grant_c && i_req0_valid;
  assign o_req1_ready  = i_reset_n && (state_q == ST_IDLE) &&  grant_c && i_req1_valid;
  assign o_rsp0_valid  = rsp_valid_q[0];
  assign o_rsp0_result = rsp_result_q[0];
  assign o_rsp0_carry  = rsp_carry_q[0];
  assign o_rsp0_err    = rsp_err_q[0];
  assign o_rsp1_valid  = rsp_valid_q[1];
  assign o_rsp1_result = rsp_result_q[1];
  assign o_rsp1_carry  = rsp_carry_q[1];
  assign o_rsp1_err    = rsp_err_q[1];
  assign o_alu_a       = alu_a_q;
  assign o_alu_b       = alu_b_q;
  assign o_alu_op      = alu_op_q;
  assign o_busy        = (state_q != ST_IDLE);

endmodule
